// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer: scheduler state encoding,
// divider iteration count and the cycles-per-minute constant.
package seq_pkg;

    localparam int         DIV_ITERS = 32;
    localparam logic [6:0] LOOPS_INF = 7'd0;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_CALC = 4'b0010,
        ST_RUN  = 4'b0100,
        ST_DONE = 4'b1000
    } sched_state_t;

    // Clock cycles in one minute; callers guarantee the product fits 32 bits.
    function automatic logic [31:0] cycles_per_min(input int unsigned clk_hz);
        logic [63:0] prod;
        prod = 64'(clk_hz) * 64'd60;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/period_divider.sv
// Restoring divider (32-bit dividend, 10-bit divisor): one quotient bit per
// cycle, dv_done pulses for one cycle after the last iteration.
module period_divider
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [9:0]  divisor,
    output logic [31:0] quotient,
    output logic        dv_done
);

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [31:0] quo_q, quo_d;
    logic [9:0]  rem_q, rem_d;
    logic [9:0]  dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [11:0] trial_s;

    // One restoring-division iteration per cycle while busy
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        trial_s = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = 10'd0;
            dvs_d  = divisor;
            cnt_d  = 6'(DIV_ITERS);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial_s[11]) begin
                rem_d = {rem_q[8:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end else begin
                rem_d = trial_s[9:0];
                quo_d = {quo_q[30:0], 1'b1};
            end
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= 32'd0;
            rem_q  <= 10'd0;
            dvs_q  <= 10'd0;
            cnt_q  <= 6'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign dv_done  = done_q;

endmodule

// File: rtl/step_scheduler.sv
// Playback scheduler: BPM -> step period, walks step_idx and counts passes.
// Optional macro STEP_SCHED_LIVE_BPM_EN enables background tempo changes in RUN.
module step_scheduler
    import seq_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEPS   = 16,
    parameter int STEPS_W = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [9:0]         BPM,
    input  logic [6:0]         Loops,
    input  logic               Start,
    input  logic               Stop,
    output logic               play_en,
    output logic               step_tick,
    output logic [STEPS_W-1:0] step_idx,
    output logic [6:0]         loop_cnt,
    output logic               done
);

    localparam logic [31:0] DIVIDEND = cycles_per_min(CLK_HZ);

    sched_state_t       state_q, state_d;
    logic [6:0]         loops_q, loops_d;
    logic [31:0]        period_q, period_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [STEPS_W-1:0] idx_q, idx_d;
    logic [6:0]         lcnt_q, lcnt_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               play_en_q, play_en_d;
    logic               start_low_q, start_low_d;

    logic               accept_s;
    logic               last_s;
    logic               wrap_s;
    logic [6:0]         lcnt_inc_s;
    logic               div_start_s;
    logic [31:0]        div_quot_s;
    logic               div_done_s;

`ifdef STEP_SCHED_LIVE_BPM_EN
    // In the default build the divider's own divisor register is the latched BPM
    logic [9:0]         bpm_q, bpm_d;
    logic               pend_q, pend_d;
    logic [31:0]        pend_period_q, pend_period_d;
`endif

    period_divider u_div (
        .clk      (CLOCK_50),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (DIVIDEND),
        .divisor  (BPM),
        .quotient (div_quot_s),
        .dv_done  (div_done_s)
    );

    // Session FSM, step counter and registered-output next values
    always_comb begin
        state_d     = state_q;
        loops_d     = loops_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lcnt_d      = lcnt_q;
        tick_d      = 1'b0;
        start_low_d = start_low_q;
        div_start_s = 1'b0;
`ifdef STEP_SCHED_LIVE_BPM_EN
        bpm_d         = bpm_q;
        pend_d        = pend_q;
        pend_period_d = pend_period_q;
`endif
        accept_s   = Start && (BPM != 10'd0) && !Stop && start_low_q;
        last_s     = (cnt_q == (period_q - 32'd1));
        wrap_s     = (idx_q == STEPS_W'(STEPS - 1));
        lcnt_inc_s = (lcnt_q == 7'd127) ? lcnt_q : (lcnt_q + 7'd1);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    loops_d     = Loops;
                    div_start_s = 1'b1;
                    idx_d       = '0;
                    lcnt_d      = 7'd0;
                    start_low_d = 1'b0;
                    state_d     = ST_CALC;
`ifdef STEP_SCHED_LIVE_BPM_EN
                    bpm_d  = BPM;
                    pend_d = 1'b0;
`endif
                end else if (!Start) begin
                    start_low_d = 1'b1;
                end else begin
                    start_low_d = start_low_q;
                end
            end
            ST_CALC: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (div_done_s) begin
                    period_d = div_quot_s;
                    cnt_d    = 32'd0;
                    idx_d    = '0;
                    tick_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else begin
                    if (last_s) begin
                        cnt_d = 32'd0;
`ifdef STEP_SCHED_LIVE_BPM_EN
                        if (pend_q) begin
                            period_d = pend_period_q;
                            pend_d   = 1'b0;
                        end else begin
                            period_d = period_q;
                        end
`endif
                        if (wrap_s) begin
                            lcnt_d = lcnt_inc_s;
                            if ((loops_q != LOOPS_INF) && (lcnt_inc_s == loops_q)) begin
                                state_d = ST_DONE;
                            end else begin
                                idx_d  = '0;
                                tick_d = 1'b1;
                            end
                        end else begin
                            idx_d  = idx_q + STEPS_W'(1);
                            tick_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
`ifdef STEP_SCHED_LIVE_BPM_EN
                    // A fresh tempo change restarts the divider and discards any pending result
                    if (div_done_s) begin
                        pend_d        = 1'b1;
                        pend_period_d = div_quot_s;
                    end else begin
                        pend_period_d = pend_period_q;
                    end
                    if ((BPM != 10'd0) && (BPM != bpm_q)) begin
                        bpm_d       = BPM;
                        div_start_s = 1'b1;
                        pend_d      = 1'b0;
                    end else begin
                        bpm_d = bpm_q;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        play_en_d = (state_d == ST_CALC) || (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // Scheduler state and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            loops_q     <= 7'd0;
            period_q    <= 32'd0;
            cnt_q       <= 32'd0;
            idx_q       <= '0;
            lcnt_q      <= 7'd0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            play_en_q   <= 1'b0;
            start_low_q <= 1'b1;
`ifdef STEP_SCHED_LIVE_BPM_EN
            bpm_q         <= 10'd0;
            pend_q        <= 1'b0;
            pend_period_q <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            loops_q     <= loops_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lcnt_q      <= lcnt_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            play_en_q   <= play_en_d;
            start_low_q <= start_low_d;
`ifdef STEP_SCHED_LIVE_BPM_EN
            bpm_q         <= bpm_d;
            pend_q        <= pend_d;
            pend_period_q <= pend_period_d;
`endif
        end
    end

    assign play_en   = play_en_q;
    assign step_tick = tick_q;
    assign step_idx  = idx_q;
    assign loop_cnt  = lcnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed + randomized bench for step_scheduler with a timing model
// derived from tempo arithmetic (period = 60*CLK_HZ/BPM).
module tb_step_scheduler;

    localparam int CLK_HZ  = 1000;
    localparam int STEPS   = 16;
    localparam int STEPS_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         BPM;
    logic [6:0]         Loops;
    logic               Start;
    logic               Stop;
    logic               play_en;
    logic               step_tick;
    logic [STEPS_W-1:0] step_idx;
    logic [6:0]         loop_cnt;
    logic               done;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    step_scheduler #(.CLK_HZ(CLK_HZ), .STEPS(STEPS), .STEPS_W(STEPS_W)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .BPM       (BPM),
        .Loops     (Loops),
        .Start     (Start),
        .Stop      (Stop),
        .play_en   (play_en),
        .step_tick (step_tick),
        .step_idx  (step_idx),
        .loop_cnt  (loop_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int period_of(input int bpm);
        return (60 * CLK_HZ) / bpm;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle at which step_tick (or done) is first seen, -1 on timeout
    task automatic wait_evt(input bit want_done, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (want_done ? done : step_tick) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Full finite session from accept to done, checking every tick
    task automatic session(input int bpm, input int loops, input string tag);
        int acc, first, prev, at, per;
        per   = period_of(bpm);
        BPM   = 10'(bpm);
        Loops = 7'(loops);
        Start = 1'b1;
        step();
        acc = cyc;
        check({tag, " play_en at accept"}, 64'(play_en), 64'd1);
        wait_evt(1'b0, 40, first);
        check({tag, " first tick latency"}, 64'(first - acc), 64'd33);
        check({tag, " first idx"}, 64'(step_idx), 64'd0);
        prev = first;
        for (int k = 1; k < loops * STEPS; k++) begin
            wait_evt(1'b0, per + 2, at);
            check({tag, " tick spacing"}, 64'(at - prev), 64'(per));
            check({tag, " tick idx"}, 64'(step_idx), 64'(k % STEPS));
            prev = at;
        end
        wait_evt(1'b1, per + 2, at);
        check({tag, " done time"}, 64'(at - first), 64'(loops * STEPS * per));
        check({tag, " loop_cnt at done"}, 64'(loop_cnt), 64'(loops));
        check({tag, " idx at done"}, 64'(step_idx), 64'(STEPS - 1));
        step();
        check({tag, " play_en after done"}, 64'(play_en), 64'd0);
    endtask

    initial begin
        int acc, first, prev, at, hi, bpm, nl, per_new;

        reset = 1'b1;
        BPM   = 10'd0;
        Loops = 7'd0;
        Start = 1'b0;
        Stop  = 1'b0;
        repeat (3) step();
        check("reset play_en", 64'(play_en), 64'd0);
        check("reset step_tick", 64'(step_tick), 64'd0);
        check("reset step_idx", 64'(step_idx), 64'd0);
        check("reset loop_cnt", 64'(loop_cnt), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b0;
        step();

        // Test 1: one pass at 120 BPM, Start held high afterwards
        session(120, 1, "t1");
        hi = 0;
        repeat (100) begin
            step();
            if (play_en) hi++;
        end
        check("t1 no auto restart", 64'(hi), 64'd0);

        // Test 2: BPM=0 is ignored
        Start = 1'b0;
        step();
        BPM   = 10'd0;
        Start = 1'b1;
        hi = 0;
        repeat (100) begin
            step();
            if (play_en) hi++;
        end
        check("t2 bpm0 stays idle", 64'(hi), 64'd0);

        // Stop and Start together in IDLE: Stop wins
        BPM  = 10'd600;
        Stop = 1'b1;
        hi = 0;
        repeat (10) begin
            step();
            if (play_en) hi++;
        end
        check("stop beats start", 64'(hi), 64'd0);
        Stop  = 1'b0;
        Start = 1'b0;
        step();

        // Test 3: endless loop, then Stop at step 5
        BPM   = 10'd600;
        Loops = 7'd0;
        Start = 1'b1;
        step();
        acc = cyc;
        wait_evt(1'b0, 40, first);
        check("t3 first tick latency", 64'(first - acc), 64'd33);
        for (int k = 0; k < 3 * STEPS; k++) wait_evt(1'b0, 102, at);
        check("t3 three passes time", 64'(at - first), 64'(3 * STEPS * period_of(600)));
        check("t3 loop_cnt 3", 64'(loop_cnt), 64'd3);
        check("t3 idx wrapped", 64'(step_idx), 64'd0);
        for (int k = 0; k < 5; k++) wait_evt(1'b0, 102, at);
        check("t3 idx 5", 64'(step_idx), 64'd5);
        Stop  = 1'b1;
        Start = 1'b0;
        step();
        check("t3 play_en after stop", 64'(play_en), 64'd0);
        check("t3 idx held", 64'(step_idx), 64'd5);
        check("t3 loop_cnt held", 64'(loop_cnt), 64'd3);
        check("t3 no done", 64'(done), 64'd0);
        Stop = 1'b0;
        hi = 0;
        repeat (200) begin
            step();
            if (step_tick || done || play_en) hi++;
        end
        check("t3 quiet after stop", 64'(hi), 64'd0);

        // Test 4: Stop during CALC, then a fresh session with random tempo
        BPM   = 10'd600;
        Start = 1'b1;
        step();
        repeat (9) step();
        check("t4 still calc", 64'(play_en), 64'd1);
        Stop = 1'b1;
        step();
        check("t4 play_en after stop", 64'(play_en), 64'd0);
        Stop  = 1'b0;
        Start = 1'b0;
        hi = 0;
        repeat (60) begin
            step();
            if (step_tick || play_en) hi++;
        end
        check("t4 no tick after calc stop", 64'(hi), 64'd0);
        bpm = int'($urandom_range(1023, 300));
        session(bpm, 1, "t4 restart");

        // Test 5: reset in RUN
        Start = 1'b0;
        step();
        BPM   = 10'd600;
        Loops = 7'd0;
        Start = 1'b1;
        step();
        wait_evt(1'b0, 40, first);
        repeat (150) step();
        reset = 1'b1;
        step();
        check("t5 play_en", 64'(play_en), 64'd0);
        check("t5 step_tick", 64'(step_tick), 64'd0);
        check("t5 step_idx", 64'(step_idx), 64'd0);
        check("t5 loop_cnt", 64'(loop_cnt), 64'd0);
        check("t5 done", 64'(done), 64'd0);
        reset = 1'b0;
        Start = 1'b0;
        step();
        Start = 1'b1;
        step();
        acc = cyc;
        wait_evt(1'b0, 40, first);
        check("t5 accept after reset", 64'(first - acc), 64'd33);
        Stop  = 1'b1;
        Start = 1'b0;
        step();
        Stop = 1'b0;
        step();

        // Randomized finite sessions
        repeat (3) begin
            Start = 1'b0;
            step();
            bpm = int'($urandom_range(1023, 400));
            nl  = int'($urandom_range(2, 1));
            session(bpm, nl, "rand");
        end

        // Test 6: tempo change 120 -> 240 at step 3
        Start = 1'b0;
        step();
        BPM   = 10'd120;
        Loops = 7'd0;
        Start = 1'b1;
        step();
        wait_evt(1'b0, 40, first);
        for (int k = 0; k < 3; k++) wait_evt(1'b0, 502, prev);
        check("t6 idx 3", 64'(step_idx), 64'd3);
        BPM = 10'd240;
        wait_evt(1'b0, 502, at);
        check("t6 step4 spacing", 64'(at - prev), 64'd500);
`ifdef STEP_SCHED_LIVE_BPM_EN
        per_new = period_of(240);
`else
        per_new = period_of(120);
`endif
        prev = at;
        for (int k = 0; k < 3; k++) begin
            wait_evt(1'b0, 502, at);
            check("t6 new spacing", 64'(at - prev), 64'(per_new));
            prev = at;
        end
        Stop  = 1'b1;
        Start = 1'b0;
        step();
        check("t6 play_en after stop", 64'(play_en), 64'd0);
        Stop = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
